// File: rtl/vm_pkg.sv
// Shared types, coin table and arithmetic helpers for the vending machine payout path.
package vm_pkg;

  localparam int unsigned NUM_COINS = 5;
  localparam int unsigned AMT_W     = 8;
  localparam int unsigned SEL_W     = 3;

  // Coin values indexed by denomination: 10, 20, 50, 100, 200.
  localparam logic [AMT_W-1:0] COIN_VALUE [NUM_COINS] = '{8'd10, 8'd20, 8'd50, 8'd100, 8'd200};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SELECT,
    ST_REQ,
    ST_DONE
  } disp_state_t;

  // Value of a denomination index; out-of-range indices are worth nothing.
  function automatic logic [AMT_W-1:0] coin_value(input logic [SEL_W-1:0] idx);
    case (idx)
      3'd0:    return COIN_VALUE[0];
      3'd1:    return COIN_VALUE[1];
      3'd2:    return COIN_VALUE[2];
      3'd3:    return COIN_VALUE[3];
      3'd4:    return COIN_VALUE[4];
      default: return '0;
    endcase
  endfunction

  // Unsigned add clamped to the all-ones amount.
  function automatic logic [AMT_W-1:0] sat_add(input logic [AMT_W-1:0] a,
                                               input logic [AMT_W-1:0] b);
    logic [AMT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[AMT_W] ? {AMT_W{1'b1}} : s[AMT_W-1:0];
  endfunction

endpackage

// File: rtl/change_coin_select.sv
// Greedy coin picker: largest in-stock denomination not exceeding the remaining amount.
module change_coin_select
  import vm_pkg::*;
(
  input  logic [7:0] remaining,
  input  logic [4:0] empty_flags,
  output logic       found,
  output logic [2:0] sel
);

  // Scan low to high so the highest qualifying denomination wins.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < NUM_COINS; i++) begin
      if (!empty_flags[i] && (COIN_VALUE[i] <= remaining)) begin
        found = 1'b1;
        sel   = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change payout controller: splits an amount into coins and drives a req/ack coin hopper.
module change_dispenser
  import vm_pkg::*;
#(
  parameter int unsigned INV_W       = 4,
  parameter int unsigned INIT_COUNT  = 8,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] change_in,
  input  logic       refill,
  input  logic       coin_ack,
  output logic       coin_req,
  output logic [2:0] coin_sel,
  output logic       busy,
  output logic       done,
  output logic [7:0] shortfall,
  output logic       timeout_err,
  output logic [4:0] empty_flags
);

  localparam int unsigned      TMR_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [INV_W-1:0] INV_INIT = INV_W'(INIT_COUNT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

  disp_state_t      state;
  logic [AMT_W-1:0] remaining;
  logic [AMT_W-1:0] pending;
  logic [INV_W-1:0] inv [NUM_COINS];
  logic [TMR_W-1:0] timer;
  logic             sel_found;
  logic [SEL_W-1:0] sel_idx;

  // Status decoded straight from registers.
  assign busy = (state != ST_IDLE);

  // A denomination is empty once its counter reaches zero.
  always_comb begin
    empty_flags = '0;
    for (int i = 0; i < NUM_COINS; i++) begin
      empty_flags[i] = (inv[i] == '0);
    end
  end

  change_coin_select u_select (
    .remaining   (remaining),
    .empty_flags (empty_flags),
    .found       (sel_found),
    .sel         (sel_idx)
  );

  // Payout FSM with amount, pending, inventory and ack-timeout registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      remaining   <= '0;
      pending     <= '0;
      timer       <= '0;
      coin_req    <= 1'b0;
      coin_sel    <= '0;
      done        <= 1'b0;
      shortfall   <= '0;
      timeout_err <= 1'b0;
      for (int i = 0; i < NUM_COINS; i++) inv[i] <= INV_INIT;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if ((change_in != '0) || (pending != '0)) begin
            remaining   <= sat_add(pending, change_in);
            pending     <= '0;
            shortfall   <= '0;
            timeout_err <= 1'b0;
            state       <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          // Zero remaining or nothing payable both finish with the leftover as shortfall.
          if (sel_found) begin
            coin_sel  <= sel_idx;
            coin_req  <= 1'b1;
            timer     <= '0;
            remaining <= sat_add(remaining, change_in);
            state     <= ST_REQ;
          end else begin
            shortfall <= remaining;
            remaining <= '0;
            pending   <= change_in;
            done      <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_REQ: begin
          if (coin_ack) begin
            // Subtract first: the selected coin never exceeds remaining.
            remaining <= sat_add(remaining - coin_value(coin_sel), change_in);
            if (inv[coin_sel] != '0) inv[coin_sel] <= inv[coin_sel] - INV_W'(1);
            coin_req  <= 1'b0;
            state     <= ST_SELECT;
          end else if (timer == TMR_LAST) begin
            coin_req    <= 1'b0;
            timeout_err <= 1'b1;
            shortfall   <= remaining;
            remaining   <= '0;
            pending     <= change_in;
            done        <= 1'b1;
            state       <= ST_DONE;
          end else begin
            timer     <= timer + TMR_W'(1);
            remaining <= sat_add(remaining, change_in);
          end
        end
        ST_DONE: begin
          pending <= sat_add(pending, change_in);
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
      // Refill overrides any same-cycle decrement.
      if (refill) begin
        for (int i = 0; i < NUM_COINS; i++) inv[i] <= INV_INIT;
      end
    end
  end

endmodule
